// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;
  localparam int WORD_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control, instruction-memory and decode-side signals of the fetch sequencer.
interface fetch_sequencer_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic                  fetch_en;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] fault_pc;
  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc
  );
  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush and occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/FSM control feeding a prefetch FIFO from a combinational instruction memory.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                    FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t                     state, state_nx;
  logic [ADDR_WIDTH-1:0]            pc, pc_nx, fault_pc, fault_pc_nx, word_idx, tgt_idx;
  logic                             pc_ok, tgt_aligned, tgt_ok, pop, push, fifo_full, fifo_empty;
  logic [CW-1:0]                    fifo_count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
  assign word_idx    = {2'b00, pc[ADDR_WIDTH-1:2]};
  assign tgt_idx     = {2'b00, bus.redirect_pc[ADDR_WIDTH-1:2]};
  assign pc_ok       = pc[1:0] == 2'b00 && word_idx < ADDR_WIDTH'(NUM_WORDS);
  assign tgt_aligned = bus.redirect_pc[1:0] == 2'b00;
  assign tgt_ok      = tgt_aligned && tgt_idx < ADDR_WIDTH'(NUM_WORDS);
  assign pop         = bus.out_valid && bus.out_ready;
  assign push        = state == RUN && bus.fetch_en && !bus.redirect_valid && pc_ok && (!fifo_full || pop);
  always_comb begin
    state_nx    = state;
    pc_nx       = push ? pc + ADDR_WIDTH'(WORD_BYTES) : pc;
    fault_pc_nx = fault_pc;
    if (bus.redirect_valid) begin
      pc_nx = bus.redirect_pc;
      // Leaving FAULT needs a target that is both aligned and inside the memory.
      if (!tgt_aligned || (state == FAULT && !tgt_ok)) begin
        state_nx    = FAULT;
        fault_pc_nx = bus.redirect_pc;
      end else if (state == FAULT) state_nx = bus.fetch_en ? RUN : IDLE;
    end else if (state == IDLE) state_nx = bus.fetch_en ? RUN : IDLE;
    else if (state == RUN) begin
      if (!pc_ok) begin
        state_nx    = FAULT;
        fault_pc_nx = pc;
      end else if (!bus.fetch_en) state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      fault_pc <= fault_pc_nx;
    end
  end
  fetch_fifo #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .wdata ({pc, bus.imem_rdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  always_ff @(posedge clk)
    assert (fifo_count <= CW'(FIFO_DEPTH));
  assign bus.imem_addr = word_idx;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_pc    = fifo_empty ? '0 : head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign bus.out_instr = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
  assign bus.fault     = state == FAULT;
  assign bus.fault_pc  = fault_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenario tasks with hand-computed expectations for fetch_sequencer.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  fetch_sequencer_if bif ();
  fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  // Memory model: word i holds the value i; out-of-range reads return a marker.
  assign bif.imem_rdata = (bif.imem_addr < 32'd128) ? bif.imem_addr : 32'hDEADBEEF;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bif.fetch_en = 0; bif.redirect_valid = 0; bif.redirect_pc = 0; bif.out_ready = 0;
    rst_n = 0;
    tick; tick;
    rst_n = 1;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bif.out_valid); end
    checks++; if (bif.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h exp 0", bif.out_pc); end
    checks++; if (bif.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h exp 0", bif.out_instr); end
    checks++; if (bif.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b exp 0", bif.fault); end
    checks++; if (bif.fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc: got %h exp 0", bif.fault_pc); end
    checks++; if (bif.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h exp 0", bif.imem_addr); end
    tick;
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_fetch: got %b exp 0", bif.out_valid); end
  endtask

  task automatic test_stream;
    bif.fetch_en = 1; bif.out_ready = 1;
    tick;
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_cycle_valid: got %b exp 0", bif.out_valid); end
    tick;
    checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL stream_second_cycle_valid: got %b exp 1", bif.out_valid); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick;
      checks++; if (bif.out_pc !== 32'(4 * k) || bif.out_instr !== 32'(k) || bif.out_valid !== 1'b1)
        begin errors++; $display("FAIL stream_%0d: got pc %h instr %h v %b exp pc %h instr %h", k, bif.out_pc, bif.out_instr, bif.out_valid, 4 * k, k); end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    bif.fetch_en = 1; bif.out_ready = 0;
    repeat (5) tick;
    checks++; if (bif.out_pc !== 32'h0 || bif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_head: got pc %h v %b exp pc 0 v 1", bif.out_pc, bif.out_valid); end
    checks++; if (bif.imem_addr !== 32'd2) begin errors++; $display("FAIL bp_imem_hold: got %h exp 2", bif.imem_addr); end
    tick;
    checks++; if (bif.imem_addr !== 32'd2 || bif.out_pc !== 32'h0) begin errors++; $display("FAIL bp_stable: got addr %h pc %h exp addr 2 pc 0", bif.imem_addr, bif.out_pc); end
    bif.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick;
      checks++; if (bif.out_pc !== 32'(4 * k) || bif.out_instr !== 32'(k))
        begin errors++; $display("FAIL bp_drain_%0d: got pc %h instr %h exp pc %h instr %h", k, bif.out_pc, bif.out_instr, 4 * k, k); end
    end
  endtask

  task automatic test_redirect;
    bif.out_ready = 0; bif.redirect_valid = 1; bif.redirect_pc = 32'h40;
    tick;
    bif.redirect_valid = 0;
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b exp 0", bif.out_valid); end
    checks++; if (bif.imem_addr !== 32'd16) begin errors++; $display("FAIL redir_imem_addr: got %h exp 10", bif.imem_addr); end
    bif.out_ready = 1;
    tick;
    checks++; if (bif.out_valid !== 1'b1 || bif.out_pc !== 32'h40 || bif.out_instr !== 32'd16)
      begin errors++; $display("FAIL redir_target: got v %b pc %h instr %h exp v 1 pc 40 instr 10", bif.out_valid, bif.out_pc, bif.out_instr); end
    tick;
    checks++; if (bif.out_pc !== 32'h44 || bif.out_instr !== 32'd17) begin errors++; $display("FAIL redir_next: got pc %h instr %h exp pc 44 instr 11", bif.out_pc, bif.out_instr); end
  endtask

  task automatic test_range_fault;
    bif.redirect_valid = 1; bif.redirect_pc = 32'h1F0;
    tick;
    bif.redirect_valid = 0;
    repeat (3) tick;
    bif.out_ready = 0;
    tick;
    checks++; if (bif.fault !== 1'b0) begin errors++; $display("FAIL range_not_yet: got %b exp 0", bif.fault); end
    tick;
    checks++; if (bif.fault !== 1'b1 || bif.fault_pc !== 32'h200) begin errors++; $display("FAIL range_fault: got f %b fpc %h exp f 1 fpc 200", bif.fault, bif.fault_pc); end
    checks++; if (bif.out_pc !== 32'h1F8 || bif.out_instr !== 32'd126) begin errors++; $display("FAIL range_head: got pc %h instr %h exp pc 1f8 instr 7e", bif.out_pc, bif.out_instr); end
    bif.out_ready = 1;
    tick;
    checks++; if (bif.out_valid !== 1'b1 || bif.out_pc !== 32'h1FC || bif.out_instr !== 32'd127) begin errors++; $display("FAIL range_drain: got v %b pc %h instr %h exp v 1 pc 1fc instr 7f", bif.out_valid, bif.out_pc, bif.out_instr); end
    tick;
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL range_empty: got %b exp 0", bif.out_valid); end
    tick;
    checks++; if (bif.out_valid !== 1'b0 || bif.fault !== 1'b1) begin errors++; $display("FAIL range_no_push: got v %b f %b exp v 0 f 1", bif.out_valid, bif.fault); end
  endtask

  task automatic test_fault_recovery;
    bif.redirect_valid = 1; bif.redirect_pc = 32'h102;
    tick;
    bif.redirect_valid = 0;
    checks++; if (bif.fault !== 1'b1 || bif.fault_pc !== 32'h102) begin errors++; $display("FAIL misalign_fault: got f %b fpc %h exp f 1 fpc 102", bif.fault, bif.fault_pc); end
    tick;
    checks++; if (bif.fault !== 1'b1 || bif.out_valid !== 1'b0) begin errors++; $display("FAIL misalign_sticky: got f %b v %b exp f 1 v 0", bif.fault, bif.out_valid); end
    bif.redirect_valid = 1; bif.redirect_pc = 32'h10;
    tick;
    bif.redirect_valid = 0;
    checks++; if (bif.fault !== 1'b0 || bif.imem_addr !== 32'd4) begin errors++; $display("FAIL recover_clear: got f %b addr %h exp f 0 addr 4", bif.fault, bif.imem_addr); end
    tick;
    checks++; if (bif.out_valid !== 1'b1 || bif.out_pc !== 32'h10 || bif.out_instr !== 32'd4) begin errors++; $display("FAIL recover_fetch: got v %b pc %h instr %h exp v 1 pc 10 instr 4", bif.out_valid, bif.out_pc, bif.out_instr); end
  endtask

  task automatic test_async_reset;
    bif.out_ready = 0; bif.redirect_valid = 1; bif.redirect_pc = 32'h1F8;
    tick;
    bif.redirect_valid = 0;
    repeat (3) tick;
    checks++; if (bif.out_valid !== 1'b1 || bif.fault !== 1'b1) begin errors++; $display("FAIL areset_setup: got v %b f %b exp v 1 f 1", bif.out_valid, bif.fault); end
    #3;
    rst_n = 0;
    #1;
    checks++; if (bif.out_valid !== 1'b0 || bif.fault !== 1'b0) begin errors++; $display("FAIL areset_immediate: got v %b f %b exp v 0 f 0", bif.out_valid, bif.fault); end
    checks++; if (bif.imem_addr !== 32'h0 || bif.fault_pc !== 32'h0 || bif.out_pc !== 32'h0) begin errors++; $display("FAIL areset_values: got addr %h fpc %h pc %h exp 0 0 0", bif.imem_addr, bif.fault_pc, bif.out_pc); end
    tick;
    rst_n = 1; bif.out_ready = 1;
    tick; tick;
    checks++; if (bif.out_valid !== 1'b1 || bif.out_pc !== 32'h0 || bif.out_instr !== 32'h0) begin errors++; $display("FAIL areset_restart: got v %b pc %h instr %h exp v 1 pc 0 instr 0", bif.out_valid, bif.out_pc, bif.out_instr); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_range_fault;
    test_fault_recovery;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
